// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NUM_REQ_MAX = 8;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over N requesters; the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  input  logic                 i_advance,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_found
);
  import wb_pkg::*;

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_gnt;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    int unsigned j;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(r_ptr) + k) % N;
      if (!w_found && i_en && i_req[j]) begin
        w_found  = 1'b1;
        w_gnt[j] = 1'b1;
        w_idx    = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;
  assign o_found   = w_found;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port through a one-entry writeback register.
// Optional pending-write scoreboard is compiled in with WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = wb_pkg::XLEN,
  parameter int unsigned REG_AW  = wb_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*REG_AW-1:0]  req_rd,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wb_stall,
`ifdef WB_SCOREBOARD_EN
  input  logic                       sb_set_valid,
  input  logic [REG_AW-1:0]          sb_set_rd,
  output logic [31:0]                busy,
`endif
  output logic                       RegWrite,
  output logic [REG_AW-1:0]          rd,
  output logic [XLEN-1:0]            WriteData,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  import wb_pkg::*;

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gidx;
  logic               w_xfer;
  logic               w_en;
  logic [REG_AW-1:0]  w_sel_rd;
  logic [XLEN-1:0]    w_sel_data;

  logic               r_regwrite;
  logic [REG_AW-1:0]  r_rd;
  logic [XLEN-1:0]    r_wdata;
  logic [IW-1:0]      r_gid;

  assign w_en = rst_n && !wb_stall;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_en      (w_en),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gidx),
    .o_found   (w_xfer)
  );

  assign req_ready  = w_gnt;
  assign w_sel_rd   = req_rd[int'(w_gidx)*REG_AW +: REG_AW];
  assign w_sel_data = req_data[int'(w_gidx)*XLEN +: XLEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_gid      <= '0;
    end else if (!wb_stall) begin
      if (w_xfer) begin
        // x0 writes complete the handshake but never reach the register file
        r_regwrite <= (w_sel_rd != '0);
        r_rd       <= w_sel_rd;
        r_wdata    <= w_sel_data;
        r_gid      <= w_gidx;
      end else begin
        r_regwrite <= 1'b0;
      end
    end
  end

  assign RegWrite  = r_regwrite;
  assign rd        = r_rd;
  assign WriteData = r_wdata;
  assign grant_id  = r_gid;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    if (r_regwrite && !wb_stall) w_busy_d[r_rd] = 1'b0;
    // set is applied after clear so it wins on a collision
    if (sb_set_valid && sb_set_rd != '0) w_busy_d[sb_set_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_d;
  end

  assign busy = r_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; scoreboard steps run when WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_AW-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]   req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wb_stall;
  logic                      RegWrite;
  logic [REG_AW-1:0]         rd;
  logic [XLEN-1:0]           WriteData;
  logic [1:0]                grant_id;
`ifdef WB_SCOREBOARD_EN
  logic                      sb_set_valid;
  logic [REG_AW-1:0]         sb_set_rd;
  logic [31:0]               busy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_stall     (wb_stall),
`ifdef WB_SCOREBOARD_EN
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .busy         (busy),
`endif
    .RegWrite     (RegWrite),
    .rd           (rd),
    .WriteData    (WriteData),
    .grant_id     (grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
    req_rd[i*REG_AW +: REG_AW] = r;
    req_data[i*XLEN +: XLEN]   = d;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [REG_AW-1:0] r,
                        input logic [XLEN-1:0] d, input logic [1:0] g);
    chk({tag, ".RegWrite"}, 64'(RegWrite), 64'(we));
    chk({tag, ".rd"}, 64'(rd), 64'(r));
    chk({tag, ".WriteData"}, 64'(WriteData), 64'(d));
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(g));
  endtask

  initial begin
    int cnt [NUM_REQ];
    rst_n     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = 3'b111;
    req_rd    = '0;
    req_data  = '0;
`ifdef WB_SCOREBOARD_EN
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
`endif
    for (int i = 0; i < 3; i++) set_req(i, REG_AW'(i + 1), 32'hA0 + 32'(i));

    // Reset with every requester valid
    step();
    step();
    chk("rst.ready", 64'(req_ready), 64'b000);
    chk_wb("rst", 1'b0, 5'd0, 32'd0, 2'd0);

    // Contention: all valid for six accepted transfers
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("cont%0d.ready", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      step();
      chk_wb($sformatf("cont%0d", c), 1'b1, REG_AW'(c % 3 + 1), 32'hA0 + 32'(c % 3), 2'(c % 3));
      cnt[grant_id]++;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("cont.count%0d", i), 64'(cnt[i]), 64'd2);
    req_valid = 3'b000;
    step();
    chk_wb("idle", 1'b0, 5'd3, 32'hA2, 2'd2);

    // Single source: req 1, rd=5
    set_req(1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    chk("single.ready", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b000;
    chk_wb("single.t1", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    step();
    chk_wb("single.t2", 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);

    // x0 write from req 0 (pointer is 2, wraps to 0)
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001;
    #1;
    chk("x0.ready", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    chk_wb("x0", 1'b0, 5'd0, 32'h1234, 2'd0);
    req_valid = 3'b111;
    #1;
    chk("x0.ptr", 64'(req_ready), 64'b010);

    // Stall with a pending write held in the writeback register
    req_valid = 3'b010;
    set_req(1, 5'd4, 32'h44);
    step();
    req_valid = 3'b100;
    set_req(2, 5'd7, 32'h77);
    wb_stall  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.ready", c), 64'(req_ready), 64'b000);
      chk_wb($sformatf("stall%0d", c), 1'b1, 5'd4, 32'h44, 2'd1);
      step();
    end
    chk_wb("stall.end", 1'b1, 5'd4, 32'h44, 2'd1);
    wb_stall = 1'b0;
    #1;
    chk("unstall.ready", 64'(req_ready), 64'b100);
    step();
    req_valid = 3'b000;
    chk_wb("unstall.t1", 1'b1, 5'd7, 32'h77, 2'd2);
    step();
    chk("unstall.t2", 64'(RegWrite), 64'd0);

    // Reset mid-operation discards the pending write
    set_req(1, 5'd9, 32'h99);
    req_valid = 3'b010;
    step();
    chk("midrst.pending", 64'(RegWrite), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", 64'(req_ready), 64'b000);
    step();
    chk_wb("midrst", 1'b0, 5'd0, 32'd0, 2'd0);
    req_valid = 3'b000;
    rst_n     = 1'b1;

`ifdef WB_SCOREBOARD_EN
    chk("sb.rst", 64'(busy), 64'd0);
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd0;
    step();
    chk("sb.x0", 64'(busy), 64'd0);
    sb_set_rd = 5'd9;
    step();
    sb_set_valid = 1'b0;
    chk("sb.set", 64'(busy), 64'(32'h200));
    set_req(0, 5'd9, 32'h5);
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    chk("sb.pending", 64'(busy), 64'(32'h200));
    step();
    chk("sb.clear", 64'(busy), 64'd0);
    req_valid = 3'b010;
    step();
    req_valid    = 3'b000;
    sb_set_valid = 1'b1;
    step();
    sb_set_valid = 1'b0;
    chk("sb.collide", 64'(busy), 64'(32'h200));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
